// File: rtl/lut_cfg_pkg.sv
// Shared types and constants for the serial LUT configuration loader.
// Frame geometry: 8 LUTs x 16 entries, one payload bit per entry.
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    HUNT,
    LOAD,
    CHECK
  } state_t;

  localparam int NUM_LUTS = 8;
  localparam int LUT_DEPTH = 16;
  localparam int PAYLOAD_BITS = NUM_LUTS * LUT_DEPTH;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for the serial clock/data pair plus a
// registered rising-edge detector on the clock; data takes the same delay.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic sdi,
  output logic rise,
  output logic sdi_q
);

  logic [STAGES-1:0] sck_s;
  logic [STAGES-1:0] sdi_s;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s <= '0;
      sdi_s <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
      sdi_q <= 1'b0;
    end else begin
      sck_s <= {sck_s[STAGES-2:0], sck};
      sdi_s <= {sdi_s[STAGES-2:0], sdi};
      prev  <= sck_s[STAGES-1];
      rise  <= sck_s[STAGES-1] & ~prev;
      sdi_q <= sdi_s[STAGES-1];
    end
  end

endmodule

// File: rtl/lut_cfg_loader.sv
// Serial bitstream loader: hunts for a sync byte, streams 128 payload
// bits out as LUT write strobes, then verifies a trailing byte checksum.
module lut_cfg_loader
  import lut_cfg_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_sck,
  input  logic       cfg_sdi,
  output logic       wr_en,
  output logic [2:0] wr_lut,
  output logic [3:0] wr_addr,
  output logic       wr_data,
  output logic       busy,
  output logic       cfg_valid,
  output logic       cfg_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0] LAST_BIT = 7'(PAYLOAD_BITS - 1);

  state_t        state;
  state_t        state_nxt;
  logic          rise;
  logic          bit_in;
  logic [7:0]    sr;
  logic [7:0]    sr_nxt;
  logic [7:0]    sum;
  logic [6:0]    cnt;
  logic [TW-1:0] tmo;
  logic [TW-1:0] tmo_nxt;
  logic          tmo_hit;
  logic          sync_hit;
  logic          load_last;
  logic          chk_last;

  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .sck   (cfg_sck),
    .sdi   (cfg_sdi),
    .rise  (rise),
    .sdi_q (bit_in)
  );

  assign sr_nxt    = {sr[6:0], bit_in};
  assign sync_hit  = rise && (state == HUNT) && (sr_nxt == SYNC_BYTE);
  assign load_last = rise && (state == LOAD) && (cnt == LAST_BIT);
  assign chk_last  = rise && (state == CHECK) && (cnt[2:0] == 3'd7);

  // An edge in the expiring cycle wins over the timeout.
  assign tmo_hit = (state != HUNT) && !rise && (tmo == TMAX);
  assign tmo_nxt = rise ? '0
                 : (tmo == TMAX) ? tmo
                 : tmo + TW'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      HUNT: begin
        if (sync_hit) state_nxt = LOAD;
      end
      LOAD: begin
        if (tmo_hit)        state_nxt = HUNT;
        else if (load_last) state_nxt = CHECK;
      end
      CHECK: begin
        if (tmo_hit || chk_last) state_nxt = HUNT;
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_comb begin
    busy = (state != HUNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      sum       <= '0;
      cnt       <= '0;
      tmo       <= '0;
      wr_en     <= 1'b0;
      wr_lut    <= '0;
      wr_addr   <= '0;
      wr_data   <= 1'b0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (rise) sr <= sr_nxt;
      unique case (state)
        HUNT: begin
          tmo <= '0;
          if (sync_hit) begin
            cnt       <= '0;
            sum       <= '0;
            cfg_valid <= 1'b0;
            cfg_err   <= 1'b0;
          end
        end
        LOAD: begin
          tmo <= tmo_nxt;
          if (tmo_hit) cfg_err <= 1'b0 | 1'b1;
          if (rise) begin
            wr_en   <= 1'b1;
            wr_lut  <= cnt[6:4];
            wr_addr <= cnt[3:0];
            wr_data <= bit_in;
            cnt     <= cnt + 7'd1;
            if (cnt[2:0] == 3'd7) sum <= sum + sr_nxt;
          end
        end
        CHECK: begin
          tmo <= tmo_nxt;
          if (tmo_hit) cfg_err <= 1'b1;
          if (rise) cnt <= cnt + 7'd1;
          if (chk_last) begin
            if (sr_nxt == sum) cfg_valid <= 1'b1;
            else               cfg_err   <= 1'b1;
          end
        end
        default: tmo <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Directed bench for lut_cfg_loader: nominal, bad checksum, hunt,
// timeout, mid-frame reset and sync-pattern-in-payload frames.
module tb_lut_cfg_loader;

  localparam logic [127:0] NOM = 128'h3F065B4F666D7D077F6F777C395E7971;
  localparam logic [7:0] NOM_SUM = 8'hA8;
  localparam logic [127:0] ALL_A5 = {16{8'hA5}};
  localparam logic [7:0] A5_SUM = 8'h50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_sck = 1'b0;
  logic       cfg_sdi = 1'b0;
  logic       wr_en;
  logic [2:0] wr_lut;
  logic [3:0] wr_addr;
  logic       wr_data;
  logic       busy;
  logic       cfg_valid;
  logic       cfg_err;

  int tests = 0;
  int fails = 0;
  int n_wr = 0;
  logic [7:0] lg [2048];

  lut_cfg_loader dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_sck   (cfg_sck),
    .cfg_sdi   (cfg_sdi),
    .wr_en     (wr_en),
    .wr_lut    (wr_lut),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .cfg_valid (cfg_valid),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      lg[n_wr % 2048] <= {wr_lut, wr_addr, wr_data};
      n_wr <= n_wr + 1;
    end
  end

  task automatic send_bit(input logic b);
    @(posedge clk);
    #1;
    cfg_sdi = b;
    cfg_sck = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    cfg_sck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_bits(input logic [127:0] p,
                           input int from, input int upto);
    for (int k = from; k < upto; k++) send_bit(p[127-k]);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({wr_en, wr_lut, wr_addr, wr_data} !== 9'd0) begin
      fails++;
      $display("FAIL reset_wr: got %h expected 000",
               {wr_en, wr_lut, wr_addr, wr_data});
    end
    tests++;
    if ({busy, cfg_valid, cfg_err} !== 3'b000) begin
      fails++;
      $display("FAIL reset_status: got %b expected 000",
               {busy, cfg_valid, cfg_err});
    end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if ({wr_en, busy, cfg_valid, cfg_err} !== 4'b0000) begin
      fails++;
      $display("FAIL idle_after_reset: got %b expected 0000",
               {wr_en, busy, cfg_valid, cfg_err});
    end
  endtask

  task automatic test_nominal();
    int base;
    logic [127:0] p;
    logic [7:0] exp;
    logic exp_en;
    p = NOM;
    send_byte(8'hA5);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL nom_busy_after_sync: got %b expected 1", busy);
    end
    base = n_wr;
    @(posedge clk);
    #1;
    cfg_sdi = p[127];
    cfg_sck = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      #1;
      exp_en = (e == 4);
      tests++;
      if (wr_en !== exp_en) begin
        fails++;
        $display("FAIL nom_latency_edge%0d: got %b expected %b",
                 e, wr_en, exp_en);
      end
    end
    cfg_sck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send_bits(p, 1, 128);
    send_byte(NOM_SUM);
    tests++;
    if (n_wr - base != 128) begin
      fails++;
      $display("FAIL nom_count: got %0d expected 128", n_wr - base);
    end
    for (int k = 0; k < 128; k++) begin
      exp = {7'(k), p[127-k]};
      tests++;
      if (lg[(base + k) % 2048] !== exp) begin
        fails++;
        $display("FAIL nom_write%0d: got %h expected %h",
                 k, lg[(base + k) % 2048], exp);
      end
    end
    tests++;
    if ({wr_lut, wr_addr, wr_data} !== 8'hFF) begin
      fails++;
      $display("FAIL nom_hold: got %h expected ff",
               {wr_lut, wr_addr, wr_data});
    end
    tests++;
    if ({busy, cfg_valid, cfg_err} !== 3'b010) begin
      fails++;
      $display("FAIL nom_status: got %b expected 010",
               {busy, cfg_valid, cfg_err});
    end
  endtask

  task automatic test_bad_checksum();
    int base;
    logic [127:0] p;
    p = NOM;
    base = n_wr;
    send_byte(8'hA5);
    tests++;
    if (cfg_valid !== 1'b0) begin
      fails++;
      $display("FAIL bad_valid_cleared: got %b expected 0", cfg_valid);
    end
    send_bits(p, 0, 128);
    send_byte(NOM_SUM ^ 8'h01);
    tests++;
    if (n_wr - base != 128) begin
      fails++;
      $display("FAIL bad_count: got %0d expected 128", n_wr - base);
    end
    tests++;
    if ({busy, cfg_valid, cfg_err} !== 3'b001) begin
      fails++;
      $display("FAIL bad_status: got %b expected 001",
               {busy, cfg_valid, cfg_err});
    end
    send_byte(8'hA5);
    tests++;
    if ({busy, cfg_err} !== 2'b10) begin
      fails++;
      $display("FAIL bad_err_clear_at_sync: got %b expected 10",
               {busy, cfg_err});
    end
    send_bits(p, 0, 128);
    send_byte(NOM_SUM);
    tests++;
    if ({busy, cfg_valid, cfg_err} !== 3'b010) begin
      fails++;
      $display("FAIL bad_recover_status: got %b expected 010",
               {busy, cfg_valid, cfg_err});
    end
  endtask

  task automatic test_sync_hunt();
    int base;
    logic [7:0] s;
    logic [127:0] p;
    p = NOM;
    s = 8'hA5;
    base = n_wr;
    send_byte(8'h00);
    send_byte(8'h5A);
    for (int i = 7; i >= 1; i--) send_bit(s[i]);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL hunt_early_load: got busy %b expected 0", busy);
    end
    tests++;
    if (n_wr != base) begin
      fails++;
      $display("FAIL hunt_no_writes: got %0d expected 0", n_wr - base);
    end
    send_bit(s[0]);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL hunt_load_entry: got busy %b expected 1", busy);
    end
    send_bits(p, 0, 128);
    send_byte(NOM_SUM);
    tests++;
    if ((n_wr - base != 128) || (cfg_valid !== 1'b1)) begin
      fails++;
      $display("FAIL hunt_frame: got %0d writes valid %b expected 128 1",
               n_wr - base, cfg_valid);
    end
  endtask

  task automatic test_timeout();
    int base;
    logic [127:0] p;
    p = NOM;
    send_byte(8'hA5);
    base = n_wr;
    send_bits(p, 0, 50);
    repeat (4092) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL tmo_early: got busy %b expected 1", busy);
    end
    @(posedge clk);
    #1;
    tests++;
    if ({busy, cfg_valid, cfg_err} !== 3'b001) begin
      fails++;
      $display("FAIL tmo_status: got %b expected 001",
               {busy, cfg_valid, cfg_err});
    end
    tests++;
    if (n_wr - base != 50) begin
      fails++;
      $display("FAIL tmo_count: got %0d expected 50", n_wr - base);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    logic [127:0] p;
    logic [7:0] exp;
    p = NOM;
    send_byte(8'hA5);
    base = n_wr;
    send_bits(p, 0, 69);
    @(posedge clk);
    #1;
    cfg_sdi = p[127-69];
    cfg_sck = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if ({wr_en, wr_lut, wr_addr, wr_data, busy, cfg_valid, cfg_err}
        !== 12'd0) begin
      fails++;
      $display("FAIL rstmid_outputs: got %h expected 000",
               {wr_en, wr_lut, wr_addr, wr_data, busy, cfg_valid, cfg_err});
    end
    repeat (4) @(posedge clk);
    #1;
    cfg_sck = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    tests++;
    if (n_wr - base != 69) begin
      fails++;
      $display("FAIL rstmid_inflight: got %0d expected 69", n_wr - base);
    end
    send_byte(8'hA5);
    base = n_wr;
    send_bits(p, 0, 128);
    send_byte(NOM_SUM);
    for (int k = 0; k < 128; k += 9) begin
      exp = {7'(k), p[127-k]};
      tests++;
      if (lg[(base + k) % 2048] !== exp) begin
        fails++;
        $display("FAIL rstmid_write%0d: got %h expected %h",
                 k, lg[(base + k) % 2048], exp);
      end
    end
    tests++;
    if ((n_wr - base != 128) || (cfg_valid !== 1'b1)) begin
      fails++;
      $display("FAIL rstmid_frame: got %0d writes valid %b expected 128 1",
               n_wr - base, cfg_valid);
    end
  endtask

  task automatic test_payload_a5();
    int base;
    logic [127:0] p;
    logic [7:0] exp;
    p = ALL_A5;
    send_byte(8'hA5);
    base = n_wr;
    send_bits(p, 0, 64);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL a5_mid_busy: got %b expected 1", busy);
    end
    send_bits(p, 64, 128);
    send_byte(A5_SUM);
    tests++;
    if (n_wr - base != 128) begin
      fails++;
      $display("FAIL a5_count: got %0d expected 128", n_wr - base);
    end
    for (int k = 0; k < 128; k += 5) begin
      exp = {7'(k), p[127-k]};
      tests++;
      if (lg[(base + k) % 2048] !== exp) begin
        fails++;
        $display("FAIL a5_write%0d: got %h expected %h",
                 k, lg[(base + k) % 2048], exp);
      end
    end
    tests++;
    if ({busy, cfg_valid, cfg_err} !== 3'b010) begin
      fails++;
      $display("FAIL a5_status: got %b expected 010",
               {busy, cfg_valid, cfg_err});
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_sync_hunt();
    test_timeout();
    test_reset_mid();
    test_payload_a5();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
